// File: rtl/powerup_scheduler.sv
// powerup_scheduler: arbitrates one shared power-up between player 1 and player 2,
// once per frame. Sequence per use: grant -> ACTIVE window -> optional HOLD (phase
// only, while the owner still overlaps a wall) -> COOLDOWN -> IDLE.
//
// Optional feature macro: POWERUP_STACK_EN
//   defined   : an owner request of the latched type during ACTIVE reloads the window.
//   undefined : every request outside IDLE is dropped.
//
// Ports:
//   frame_clk, Reset          frame clock, synchronous active-high reset
//   pN_req, pN_type           pickup request and type (0 = boost, 1 = phase)
//   pN_onWall                 player N overlaps a wall tile (only owner's is used)
//   pN_speedBoost_active      boost enable to player N
//   pN_wallPhase_active       phase enable to player N
//   pN_grant                  one-frame pulse on a grant to player N
//   owner                     current or last owner (0 = P1, 1 = P2)
//   busy                      high in every state except IDLE
//   time_left                 remaining count of the ACTIVE or COOLDOWN window
module powerup_scheduler #(
  parameter int unsigned BOOST_FRAMES    = 300,
  parameter int unsigned PHASE_FRAMES    = 120,
  parameter int unsigned COOLDOWN_FRAMES = 180,
  parameter int unsigned CNT_W           = 10
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             p1_req,
  input  logic             p1_type,
  input  logic             p2_req,
  input  logic             p2_type,
  input  logic             p1_onWall,
  input  logic             p2_onWall,
  output logic             p1_speedBoost_active,
  output logic             p1_wallPhase_active,
  output logic             p2_speedBoost_active,
  output logic             p2_wallPhase_active,
  output logic             p1_grant,
  output logic             p2_grant,
  output logic             owner,
  output logic             busy,
  output logic [CNT_W-1:0] time_left
);

  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  // Elaboration-time parameter legality checks
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("powerup_scheduler: CNT_W must be 1..31");
  end
  if (BOOST_FRAMES < 1 || BOOST_FRAMES > CNT_MAX) begin : g_bad_boost
    $error("powerup_scheduler: BOOST_FRAMES out of range");
  end
  if (PHASE_FRAMES < 1 || PHASE_FRAMES > CNT_MAX) begin : g_bad_phase
    $error("powerup_scheduler: PHASE_FRAMES out of range");
  end
  if (COOLDOWN_FRAMES > CNT_MAX + 1) begin : g_bad_cool
    $error("powerup_scheduler: COOLDOWN_FRAMES out of range");
  end

  localparam logic [CNT_W-1:0] BOOST_LOAD = CNT_W'(BOOST_FRAMES - 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  =
    CNT_W'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_HOLD     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             owner_d;
  logic             type_q, type_d;
  logic             rr_q, rr_d;      // 0 favours P1 on a tie, 1 favours P2
  logic             win;
  logic             go_cool;
  logic             en_d;
  logic             p1_grant_d, p2_grant_d;
  logic             owner_on_wall;
  logic             stack_hit;

  assign owner_on_wall = owner ? p2_onWall : p1_onWall;

  // Owner re-requesting the same type while the window is running
`ifdef POWERUP_STACK_EN
  assign stack_hit = (owner ? p2_req : p1_req) && ((owner ? p2_type : p1_type) == type_q);
`else
  assign stack_hit = 1'b0;
`endif

  // Next-state, counter and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = time_left;
    owner_d    = owner;
    type_d     = type_q;
    rr_d       = rr_q;
    win        = 1'b0;
    go_cool    = 1'b0;
    p1_grant_d = 1'b0;
    p2_grant_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p1_req || p2_req) begin
          // Tie goes to the favoured player; the pointer then favours the loser
          win = (p1_req && p2_req) ? rr_q : p2_req;
          if (p1_req && p2_req) rr_d = ~win;
          owner_d    = win;
          type_d     = win ? p2_type : p1_type;
          cnt_d      = type_d ? PHASE_LOAD : BOOST_LOAD;
          p1_grant_d = ~win;
          p2_grant_d = win;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (stack_hit) begin
          cnt_d = type_q ? PHASE_LOAD : BOOST_LOAD;
        end else if (time_left != '0) begin
          cnt_d = time_left - CNT_W'(1);
        end else if (type_q && owner_on_wall) begin
          state_d = S_HOLD;
        end else begin
          go_cool = 1'b1;
        end
      end
      S_HOLD: begin
        // Never release a phasing player while still inside a wall
        if (!owner_on_wall) go_cool = 1'b1;
      end
      S_COOLDOWN: begin
        if (time_left != '0) cnt_d = time_left - CNT_W'(1);
        else                 state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_cool) begin
      if (COOLDOWN_FRAMES == 0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_COOLDOWN;
        cnt_d   = COOL_LOAD;
      end
    end

    en_d = (state_d == S_ACTIVE) || (state_d == S_HOLD);
  end

  // State and registered outputs
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q              <= S_IDLE;
      time_left            <= '0;
      owner                <= 1'b0;
      type_q               <= 1'b0;
      rr_q                 <= 1'b0;
      busy                 <= 1'b0;
      p1_grant             <= 1'b0;
      p2_grant             <= 1'b0;
      p1_speedBoost_active <= 1'b0;
      p1_wallPhase_active  <= 1'b0;
      p2_speedBoost_active <= 1'b0;
      p2_wallPhase_active  <= 1'b0;
    end else begin
      state_q              <= state_d;
      time_left            <= cnt_d;
      owner                <= owner_d;
      type_q               <= type_d;
      rr_q                 <= rr_d;
      busy                 <= (state_d != S_IDLE);
      p1_grant             <= p1_grant_d;
      p2_grant             <= p2_grant_d;
      p1_speedBoost_active <= en_d & ~owner_d & ~type_d;
      p1_wallPhase_active  <= en_d & ~owner_d &  type_d;
      p2_speedBoost_active <= en_d &  owner_d & ~type_d;
      p2_wallPhase_active  <= en_d &  owner_d &  type_d;
    end
  end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Testbench for powerup_scheduler: directed scenarios plus randomized traffic,
// checked against a timestamp-based reference model through a scoreboard queue.
module tb_powerup_scheduler;

  localparam int BOOST = 300;
  localparam int PHASE = 120;
  localparam int CD    = 180;
  localparam int CW    = 10;
  localparam int NEVER = 32'h7fff_ffff;
`ifdef POWERUP_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  logic          frame_clk;
  logic          Reset;
  logic          p1_req, p1_type, p2_req, p2_type, p1_onWall, p2_onWall;
  logic          p1_speedBoost_active, p1_wallPhase_active;
  logic          p2_speedBoost_active, p2_wallPhase_active;
  logic          p1_grant, p2_grant, owner, busy;
  logic [CW-1:0] time_left;

  typedef struct packed {
    logic          p1b;
    logic          p1p;
    logic          p2b;
    logic          p2p;
    logic          g1;
    logic          g2;
    logic          own;
    logic          busy;
    logic [CW-1:0] tl;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n        = 0;

  // Reference model: absolute frame timestamps instead of down-counters
  bit m_gr, m_hold, m_own, m_type, m_rr;
  int m_en_end;   // edge at which the active window expires
  int m_idle_at;  // first edge at which a request can be granted

  powerup_scheduler #(
    .BOOST_FRAMES(BOOST), .PHASE_FRAMES(PHASE), .COOLDOWN_FRAMES(CD), .CNT_W(CW)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .p1_req(p1_req), .p1_type(p1_type), .p2_req(p2_req), .p2_type(p2_type),
    .p1_onWall(p1_onWall), .p2_onWall(p2_onWall),
    .p1_speedBoost_active(p1_speedBoost_active), .p1_wallPhase_active(p1_wallPhase_active),
    .p2_speedBoost_active(p2_speedBoost_active), .p2_wallPhase_active(p2_wallPhase_active),
    .p1_grant(p1_grant), .p2_grant(p2_grant), .owner(owner), .busy(busy),
    .time_left(time_left)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic int dur(input bit t);
    return t ? PHASE : BOOST;
  endfunction

  // Drive one frame of inputs, predict the outputs after the next edge, advance
  task automatic cyc(input bit rst, input bit r1, input bit t1, input bit r2,
                     input bit t2, input bit w1, input bit w2);
    bit   g1, g2, win, wall;
    obs_t e;
    g1 = 1'b0;
    g2 = 1'b0;
    Reset = rst; p1_req = r1; p1_type = t1; p2_req = r2; p2_type = t2;
    p1_onWall = w1; p2_onWall = w2;

    if (rst) begin
      m_gr = 0; m_hold = 0; m_own = 0; m_type = 0; m_rr = 0;
      m_idle_at = n + 1;
    end else if (n >= m_idle_at) begin
      if (r1 || r2) begin
        win = (r1 && r2) ? m_rr : r2;
        if (r1 && r2) m_rr = ~win;
        m_own     = win;
        m_type    = win ? t2 : t1;
        m_gr      = 1;
        m_hold    = 0;
        m_en_end  = n + dur(m_type);
        m_idle_at = NEVER;
        g1 = ~win;
        g2 = win;
      end
    end else if (m_gr) begin
      wall = m_own ? w2 : w1;
      if (m_hold) begin
        if (!wall) begin
          m_gr = 0; m_hold = 0; m_idle_at = n + CD + 1;
        end
      end else if (STACK && (m_own ? r2 : r1) && ((m_own ? t2 : t1) == m_type)) begin
        m_en_end = n + dur(m_type);
      end else if (n == m_en_end) begin
        if (m_type && wall) m_hold = 1;
        else begin
          m_gr = 0; m_idle_at = n + CD + 1;
        end
      end
    end

    e.p1b  = m_gr & ~m_own & ~m_type;
    e.p1p  = m_gr & ~m_own &  m_type;
    e.p2b  = m_gr &  m_own & ~m_type;
    e.p2p  = m_gr &  m_own &  m_type;
    e.g1   = g1;
    e.g2   = g2;
    e.own  = m_own;
    e.busy = m_gr || (n + 1 < m_idle_at);
    if (m_gr)                 e.tl = m_hold ? '0 : CW'(m_en_end - 1 - n);
    else if (n + 1 < m_idle_at) e.tl = CW'(m_idle_at - 2 - n);
    else                      e.tl = '0;
    exp_q.push_back(e);

    @(posedge frame_clk);
    #1;
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every frame the DUT presents a full output vector
  initial begin : monitor
    obs_t e, a;
    int   mn;
    mn = 0;
    forever begin
      @(negedge frame_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {p1_speedBoost_active, p1_wallPhase_active, p2_speedBoost_active,
             p2_wallPhase_active, p1_grant, p2_grant, owner, busy, time_left};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs frame=%0d act{p1b,p1p,p2b,p2p,g1,g2,own,busy}=%b tl=%0d exp=%b tl=%0d",
                   mn, a[CW+7:CW], a.tl, e[CW+7:CW], e.tl);
        end
        mn++;
      end
    end
  end

  initial begin : stim
    bit w1, w2;
    m_idle_at = NEVER;
    w1 = 0;
    w2 = 0;
    Reset = 1; p1_req = 0; p1_type = 0; p2_req = 0; p2_type = 0;
    p1_onWall = 0; p2_onWall = 0;
    #2;

    // Single P1 boost: window, cooldown, idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(520);

    // Tie just after reset: P1 wins, then P2 wins the next tie
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) cyc(0, 1, 0, 1, 0, 0, 0);
    idle(10);

    // P2 phase held on a wall past expiry; P1 wall toggling is irrelevant
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 140; i++) cyc(0, 0, 0, 0, 0, i[0], 1);
    for (int i = 0; i < 250; i++) cyc(0, 0, 0, 0, 0, i[1], 0);

    // P2 requesting throughout P1's window and cooldown
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    idle(10);

    // Reset in the middle of ACTIVE at time_left = 57
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(242);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Owner re-request of the same type at time_left = 10
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(289);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(520);

    // Randomized traffic with sticky wall flags and rare resets
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) w1 = ~w1;
      if ($urandom_range(0, 39) == 0) w2 = ~w2;
      cyc($urandom_range(0, 2999) == 0,
          $urandom_range(0, 99) < 4, 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 4, 1'($urandom_range(0, 1)),
          w1, w2);
    end

    repeat (3) @(negedge frame_clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain act=%0d pending exp=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/powerup_scheduler.md
Name: powerup_scheduler

Overview:
- Arbitrates one shared power-up resource between player 1 and player 2.
- Times each grant and drives the speedBoost_active / wallPhase_active inputs of both player movement blocks.
- Runs once per frame on frame_clk, sitting between power-up pickup detection and the two player blocks.
- Sequence per use: grant, fixed-duration active window, optional wall-exit hold for phase, cooldown, then idle.

Parameters:
- BOOST_FRAMES, 300, frames a speed boost stays active (legal range 1..2^CNT_W-1).
- PHASE_FRAMES, 120, frames a wall phase stays active before the hold check (legal range 1..2^CNT_W-1).
- COOLDOWN_FRAMES, 180, idle frames after release before a new grant (0 = no cooldown).
- CNT_W, 10, width of the frame counter.

Ports:
- frame_clk  in  1  frame clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- p1_req  in  1  player 1 pickup request, sampled each frame.
- p1_type  in  1  player 1 requested type: 0 = boost, 1 = phase.
- p2_req  in  1  player 2 pickup request.
- p2_type  in  1  player 2 requested type.
- p1_onWall  in  1  player 1 currently overlaps a wall tile.
- p2_onWall  in  1  player 2 currently overlaps a wall tile.
- p1_speedBoost_active  out  1  boost enable to player 1.
- p1_wallPhase_active  out  1  phase enable to player 1.
- p2_speedBoost_active  out  1  boost enable to player 2.
- p2_wallPhase_active  out  1  phase enable to player 2.
- p1_grant  out  1  one-frame pulse when player 1 wins a grant.
- p2_grant  out  1  one-frame pulse when player 2 wins a grant.
- owner  out  1  current or last owner: 0 = P1, 1 = P2.
- busy  out  1  high in every state except IDLE.
- time_left  out  CNT_W  remaining count of the current ACTIVE or COOLDOWN window.

Behaviour:
- Reset (synchronous, any state, including mid-grant):
  - state = IDLE.
  - All enable outputs, grants and busy = 0.
  - owner = 0, time_left = 0.
  - Round-robin pointer set to favour P1.
- States: IDLE, ACTIVE, HOLD, COOLDOWN. Outputs are registered.
- IDLE:
  - Exactly one req high: that player wins.
  - Both high in the same frame: the player favoured by the round-robin pointer wins, and the pointer then flips to favour the loser.
  - Grant edge: grant pulse = 1 for one frame, owner updated, type latched, time_left = DURATION-1, state to ACTIVE.
  - The owner's enable for the latched type rises on that same edge. The other three enables stay 0.
- ACTIVE:
  - time_left != 0: decrement by 1.
  - time_left == 0 and type = boost: go to COOLDOWN.
  - time_left == 0 and type = phase: if owner onWall = 1, go to HOLD; otherwise go to COOLDOWN.
  - Result: the enable is high for exactly DURATION frames, counted from the grant edge.
- HOLD:
  - Phase enable stays high and time_left stays 0.
  - Leaves for COOLDOWN on the first frame the owner's onWall = 0. This keeps a player from being trapped inside a wall.
  - No timeout.
- Entering COOLDOWN:
  - All enables drop on the transition edge.
  - time_left = COOLDOWN_FRAMES-1.
  - If COOLDOWN_FRAMES = 0, go straight to IDLE instead; a request is then accepted on the next edge.
- COOLDOWN: decrement time_left; at 0, go to IDLE.
- Requests outside IDLE are dropped, not queued. The requester must still be asserting the request when IDLE is reached.
- The non-owner's onWall is ignored in every state.
- At most one of the four enables is high at any time.
- The counter never wraps. Parameter legality is checked by elaboration assertions.

Optional Feature:
- Macro: POWERUP_STACK_EN.
- Defined: in ACTIVE, a request from the owner with the same type as the latched type reloads time_left = DURATION-1. No grant pulse. Other requests are dropped.
- Not defined: all requests in ACTIVE are dropped.

Test Plan:
- Reset, then p1_req=1 type=0 for one frame -> p1_grant pulse. p1_speedBoost_active high for exactly 300 frames, busy=1, owner=0. Then 180 cooldown frames, then IDLE with busy=0.
- Both requests high in IDLE just after reset -> P1 wins, owner=0. After cooldown, both high again -> P2 wins, owner=1.
- p2 phase grant with p2_onWall=1 at expiry -> p2_wallPhase_active stays high in HOLD. It drops on the edge after p2_onWall falls, then cooldown.
- p2_req asserted throughout P1's ACTIVE and COOLDOWN -> no p2 enable until IDLE. p2_grant pulses on the first IDLE frame.
- Reset asserted mid-ACTIVE at time_left=57 -> next edge: all outputs 0, time_left=0, state IDLE.
- POWERUP_STACK_EN defined, P1 re-requests boost at time_left=10 -> time_left=299, boost held 300 further frames. Macro undefined: expires on schedule.
